// File: rtl/pp_requant_sat_stage.sv
// Requantizes signed accumulator words to int8 (rounded shift, saturation) into a small output FIFO; 3-cycle accept-to-dout latency.
// din_ready is credit based (FIFO plus in-flight words < FIFO_DEPTH, pops credited a cycle late); PP_REQUANT_ZERO_POINT_EN adds a zero_point offset.
module pp_requant_sat_stage #(
  parameter int IN_W       = 24,
  parameter int OUT_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [IN_W-1:0]  din,
  input  logic                    din_last,
  input  logic                    din_valid,
  output logic                    din_ready,
  input  logic [4:0]              shift,
  output logic signed [OUT_W-1:0] dout,
  output logic                    dout_last,
  output logic                    dout_valid,
  input  logic                    dout_ready,
`ifdef PP_REQUANT_ZERO_POINT_EN
  input  logic signed [7:0]       zero_point,
`endif
  output logic [CNT_W-1:0]        sat_count,
  input  logic                    sat_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 2;
  localparam int W1 = IN_W + 1;
  localparam logic [4:0] MAX_SHIFT = 5'(IN_W - 1);
  localparam logic signed [W1-1:0] PIX_MAX = W1'(2**(OUT_W-1) - 1);
  localparam logic signed [W1-1:0] PIX_MIN = W1'(-(2**(OUT_W-1)));

  logic                   ready_en;
  logic                   accept;
  logic [4:0]             s_amt;
  logic signed [W1-1:0]   round_bias;
  logic signed [W1-1:0]   t_sum;
  logic signed [W1-1:0]   r_shift;
  logic                   s1_valid;
  logic                   s1_last;
  logic signed [W1-1:0]   s1_r;
  logic signed [W1-1:0]   zp_sum;
  logic [OUT_W-1:0]       pix;
  logic                   sat_evt;
  logic                   s2_valid;
  logic                   s2_last;
  logic                   s2_sat;
  logic [OUT_W-1:0]       s2_pix;
  logic [OUT_W-1:0]       mem_pix [FIFO_DEPTH];
  logic                   mem_last [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            fifo_count;
  logic                   push;
  logic                   pop;
  logic [CW-1:0]          occupancy;

  // Occupancy uses registered state only, so a pop this cycle frees its credit next cycle.
  assign occupancy = CW'(fifo_count) + CW'(s1_valid) + CW'(s2_valid);
  assign din_ready = ready_en && (occupancy < CW'(FIFO_DEPTH));
  assign accept    = din_valid && din_ready;

  always_comb begin
    s_amt      = (shift > MAX_SHIFT) ? MAX_SHIFT : shift;
    round_bias = '0;
    if (s_amt != 5'd0) round_bias = W1'(1) << (s_amt - 5'd1);
    t_sum   = $signed({din[IN_W-1], din}) + round_bias;
    r_shift = t_sum >>> s_amt;
  end

`ifdef PP_REQUANT_ZERO_POINT_EN
  assign zp_sum = s1_r + $signed({{(W1-8){zero_point[7]}}, zero_point});
`else
  assign zp_sum = s1_r;
`endif

  always_comb begin
    pix     = zp_sum[OUT_W-1:0];
    sat_evt = 1'b0;
    if (zp_sum > PIX_MAX) begin
      pix     = PIX_MAX[OUT_W-1:0];
      sat_evt = 1'b1;
    end else if (zp_sum < PIX_MIN) begin
      pix     = PIX_MIN[OUT_W-1:0];
      sat_evt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_en <= 1'b0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_r     <= '0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_sat   <= 1'b0;
      s2_pix   <= '0;
    end else begin
      ready_en <= 1'b1;
      s1_valid <= accept;
      if (accept) begin
        s1_r    <= r_shift;
        s1_last <= din_last;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_pix  <= pix;
        s2_last <= s1_last;
        s2_sat  <= sat_evt;
      end
    end
  end

  assign push       = s2_valid;
  assign dout_valid = (fifo_count != '0);
  assign pop        = dout_valid && dout_ready;
  assign dout       = $signed(mem_pix[rd_ptr]);
  assign dout_last  = mem_last[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_pix[i]  <= '0;
        mem_last[i] <= 1'b0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        mem_pix[wr_ptr]  <= s2_pix;
        mem_last[wr_ptr] <= s2_last;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (push && s2_sat && (sat_count != '1)) begin
      sat_count <= sat_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pp_requant_sat_stage.sv
// Bench for pp_requant_sat_stage: vector table, timing/backpressure/counter/reset sequences, random traffic against an arithmetic model.
module tb_pp_requant_sat_stage;
  localparam int FIFO_DEPTH = 4;

  logic               clk;
  logic               reset;
  logic signed [23:0] din;
  logic               din_last;
  logic               din_valid;
  logic               din_ready;
  logic [4:0]         shift;
  logic signed [7:0]  dout;
  logic               dout_last;
  logic               dout_valid;
  logic               dout_ready;
  logic [15:0]        sat_count;
  logic               sat_clr;
`ifdef PP_REQUANT_ZERO_POINT_EN
  logic signed [7:0]  zero_point;
`endif

  pp_requant_sat_stage #(.IN_W(24), .OUT_W(8), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .din(din), .din_last(din_last), .din_valid(din_valid),
    .din_ready(din_ready), .shift(shift), .dout(dout), .dout_last(dout_last),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
`ifdef PP_REQUANT_ZERO_POINT_EN
    .zero_point(zero_point),
`endif
    .sat_count(sat_count), .sat_clr(sat_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic signed [23:0] d;
    logic [4:0]         sh;
    logic signed [7:0]  px;
    int                 sat;
  } vec_t;

  typedef struct {
    logic signed [7:0] pix;
    logic              last;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  int   outstanding = 0;
  int   pops = 0;
  int   exp_sat = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: real-valued floor((din + half) / 2^s), then clamp to int8.
  function automatic void model(input logic signed [23:0] d, input logic [4:0] sh,
                                output logic signed [7:0] px, output bit sat);
    longint s, den, num, q;
    s   = (sh > 5'd23) ? 23 : longint'(sh);
    den = longint'(2) ** s;
    num = longint'(d) + ((s > 0) ? den / 2 : 0);
    q   = num / den;
    if ((num % den != 0) && (num < 0)) q = q - 1;
    sat = (q > 127) || (q < -128);
    if (q > 127) q = 127;
    else if (q < -128) q = -128;
    px = q[7:0];
  endfunction

  task automatic sample();
    logic signed [7:0] px;
    bit   sat;
    exp_t e;
    int   pre;
    if (reset) return;
    pre = outstanding;
    if (dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra: got dout=%0d, expected no word", dout);
      end else begin
        e = exp_q.pop_front();
        chk("sb_dout", $signed(dout), e.pix);
        chk("sb_last", dout_last, e.last);
        outstanding--;
        pops++;
      end
    end
    if (din_valid && din_ready) begin
      chk("no_overflow", pre < FIFO_DEPTH, 1);
      model(din, shift, px, sat);
      e.pix  = px;
      e.last = din_last;
      exp_q.push_back(e);
      outstanding++;
      if (sat) exp_sat++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int maxc, output bit ok);
    ok = dout_valid;
    for (int i = 0; i < maxc && !ok; i++) begin
      tick();
      ok = dout_valid;
    end
  endtask

  task automatic drain(input int maxc);
    dout_ready = 1'b1;
    din_valid  = 1'b0;
    for (int i = 0; i < maxc && (exp_q.size() != 0 || dout_valid); i++) tick();
  endtask

  initial begin
    vec_t vec [18];
    bit   ok, took;
    int   acc, n, sat_sum, tmp, first_idx, last_idx, vcount, lcount, lidx, pops0, diff;
    logic [15:0] sat_before;

    vec[0]  = '{24'sd384,      5'd8,  8'sd2,    0};
    vec[1]  = '{-24'sd128,     5'd8,  8'sd0,    0};
    vec[2]  = '{-24'sd129,     5'd8,  -8'sd1,   0};
    vec[3]  = '{24'sh7FFFFF,   5'd8,  8'sd127,  1};
    vec[4]  = '{24'sh800000,   5'd8,  -8'sd128, 1};
    vec[5]  = '{24'sd5,        5'd0,  8'sd5,    0};
    vec[6]  = '{24'sh400000,   5'd31, 8'sd1,    0};
    vec[7]  = '{24'sd3,        5'd1,  8'sd2,    0};
    vec[8]  = '{-24'sd3,       5'd1,  -8'sd1,   0};
    vec[9]  = '{-24'sd1,       5'd1,  8'sd0,    0};
    vec[10] = '{24'sd200,      5'd0,  8'sd127,  1};
    vec[11] = '{-24'sd200,     5'd0,  -8'sd128, 1};
    vec[12] = '{24'sh7FFFFF,   5'd23, 8'sd1,    0};
    vec[13] = '{24'sh800000,   5'd23, -8'sd1,   0};
    vec[14] = '{24'sd32639,    5'd8,  8'sd127,  0};
    vec[15] = '{24'sd32640,    5'd8,  8'sd127,  1};
    vec[16] = '{-24'sd32896,   5'd8,  -8'sd128, 0};
    vec[17] = '{-24'sd32897,   5'd8,  -8'sd128, 1};

    reset = 1'b1; din = '0; din_last = 1'b0; din_valid = 1'b0; shift = '0;
    dout_ready = 1'b1; sat_clr = 1'b0;
`ifdef PP_REQUANT_ZERO_POINT_EN
    zero_point = '0;
`endif
    #1;
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_sat_count", sat_count, 0);
    chk("rst_din_ready", din_ready, 0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1 chk("rel_din_ready_before_edge", din_ready, 0);
    @(posedge clk); #1;
    chk("rel_din_ready", din_ready, 1);

    // First-word latency
    shift = 5'd8; din = 24'sd384; din_valid = 1'b1;
    chk("lat_ready", din_ready, 1);
    tick(); din_valid = 1'b0;
    tick(); chk("lat_n2_valid", dout_valid, 0);
    tick(); chk("lat_n3_valid", dout_valid, 1);
    chk("lat_n3_dout", dout, 2);
    chk("lat_sat", sat_count, 0);
    tick();

    sat_sum = 0;
    for (int i = 0; i < 18; i++) begin
      sat_before = sat_count;
      shift = vec[i].sh; din = vec[i].d; din_valid = 1'b1;
      chk("vec_ready", din_ready, 1);
      tick(); din_valid = 1'b0;
      wait_valid(8, ok);
      chk("vec_timeout", ok, 1);
      chk("vec_dout", $signed(dout), vec[i].px);
      diff = int'(sat_count) - int'(sat_before);
      chk("vec_sat", diff, vec[i].sat);
      sat_sum += vec[i].sat;
      tick();
    end
    chk("vec_sat_total", sat_count, sat_sum);

    // Backpressure: FIFO plus pipeline cap accepted words at FIFO_DEPTH
    dout_ready = 1'b0; shift = 5'd0; din = 24'sd10; din_valid = 1'b1; acc = 0;
    for (int c = 0; c < 12; c++) begin
      took = din_ready;
      tick();
      if (took) begin acc++; din = 24'(10 + acc); end
    end
    chk("bp_accepted", acc, FIFO_DEPTH);
    chk("bp_ready_low", din_ready, 0);
    chk("bp_valid", dout_valid, 1);
    chk("bp_hold_dout", dout, 10);
    pops0 = pops;
    drain(20);
    chk("bp_drained", pops - pops0, FIFO_DEPTH);

    // Steady state with a last marker on word 7
    dout_ready = 1'b1; shift = 5'd0; din_valid = 1'b1;
    first_idx = -1; last_idx = -1; vcount = 0; lcount = 0; lidx = -1;
    for (int c = 0; c < 20; c++) begin
      if (c < 12) begin
        din = 24'(100 + c); din_last = (c == 7);
        chk("ss_ready", din_ready, 1);
      end else begin
        din_valid = 1'b0; din_last = 1'b0;
      end
      if (dout_valid) begin
        vcount++;
        if (first_idx < 0) first_idx = c;
        last_idx = c;
        if (dout_last) begin lcount++; lidx = c; end
      end
      tick();
    end
    chk("ss_first", first_idx, 3);
    chk("ss_span", last_idx - first_idx + 1, 12);
    chk("ss_count", vcount, 12);
    chk("ss_last_cnt", lcount, 1);
    chk("ss_last_pos", lidx, 10);

    // Saturation counter: clear, fill to all-ones, hold
    sat_clr = 1'b1; tick(); sat_clr = 1'b0;
    chk("clr", sat_count, 0);
    shift = 5'd0; din = 24'sh7FFFFF; din_valid = 1'b1; n = 0;
    for (int c = 0; c < 70000 && n < 65535; c++) begin
      took = din_ready;
      tick();
      if (took) n++;
    end
    din_valid = 1'b0;
    chk("sat_words", n, 65535);
    repeat (5) tick();
    chk("sat_full", sat_count, 16'hFFFF);
    din_valid = 1'b1; n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      took = din_ready;
      tick();
      if (took) n++;
    end
    din_valid = 1'b0;
    repeat (5) tick();
    chk("sat_hold", sat_count, 16'hFFFF);

    // sat_clr on the same edge as a saturating write
    din_valid = 1'b1;
    chk("clr_evt_ready", din_ready, 1);
    tick(); din_valid = 1'b0;
    tick(); sat_clr = 1'b1;
    tick(); sat_clr = 1'b0;
    chk("clr_coincident", sat_count, 0);
    chk("clr_word_arrived", dout_valid, 1);
    tick();
    chk("clr_after", sat_count, 0);
    drain(10);

    // Asynchronous reset with three words in flight
    dout_ready = 1'b0; shift = 5'd0; din = 24'sh7FFFFF; din_last = 1'b1; din_valid = 1'b1;
    tick(); din_last = 1'b0;
    tick(); tick(); din_valid = 1'b0;
    chk("pre_rst_valid", dout_valid, 1);
    chk("pre_rst_last", dout_last, 1);
    chk("pre_rst_sat", sat_count, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", dout_valid, 0);
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_last", dout_last, 0);
    chk("mid_rst_sat", sat_count, 0);
    chk("mid_rst_ready", din_ready, 0);
    exp_q.delete(); outstanding = 0; exp_sat = 0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", din_ready, 1);
    shift = 5'd8; din = 24'sd256; dout_ready = 1'b1; din_valid = 1'b1;
    tick(); din_valid = 1'b0;
    tick(); chk("post_rst_n2_valid", dout_valid, 0);
    tick(); chk("post_rst_n3_valid", dout_valid, 1);
    chk("post_rst_dout", dout, 1);
    tick();

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      din_valid = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0) tmp = int'($urandom_range(0, 600)) - 300;
      else tmp = int'($urandom());
      din = tmp[23:0];
      shift = 5'($urandom_range(0, 31));
      din_last = ($urandom_range(0, 7) == 0);
      dout_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    din_last = 1'b0;
    drain(40);
    chk("rand_queue_empty", exp_q.size(), 0);
    chk("rand_no_valid", dout_valid, 0);
    chk("rand_sat_count", sat_count, (exp_sat > 65535) ? 65535 : exp_sat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
